uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one uart_tx byte port (tx_data/tx_wr/tx_busy) among
//  NUM_REQ byte-stream requesters (CPU console, debug monitor, etc.). Grants are

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one uart_tx byte port among NUM_REQ requesters.
// The owner keeps the transmitter until it sends a byte marked last, or idles HOLD_MAX cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   tx_wr,
  input  logic                   tx_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [PW:0]   NR_W     = (PW+1)'(NUM_REQ);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_MAX - 1);

  typedef enum logic [2:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD} state_t;

  state_t                     state_q;
  logic [NUM_REQ-1:0]         grant_q, req_ready_q;
  logic [7:0]                 tx_data_q;
  logic                       tx_wr_q, last_q;
  logic [CW-1:0]              hold_cnt_q;
  logic [PW-1:0]              rr_ptr_q, owner_q;

  logic [NUM_REQ-1:0][7:0]    data_v;
  logic                       win_found;
  logic [PW-1:0]              win_idx;
  logic [PW:0]                cand;
  logic [NUM_REQ-1:0]         win_oh, own_oh;

  assign data_v = req_data;
  assign win_oh = NUM_REQ'(1) << win_idx;
  assign own_oh = NUM_REQ'(1) << owner_q;

  // Scan from rr_ptr+1 upward with wrap; descending loop so the nearest valid wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (cand >= NR_W) cand = cand - NR_W;
      if (req_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB;
      grant_q     <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_wr_q     <= 1'b0;
      last_q      <= 1'b0;
      hold_cnt_q  <= '0;
      rr_ptr_q    <= PW'(NUM_REQ - 1);
      owner_q     <= '0;
    end else begin
      tx_wr_q     <= 1'b0;
      req_ready_q <= '0;
      unique case (state_q)
        ARB: begin
          if (win_found) begin
            owner_q     <= win_idx;
            grant_q     <= win_oh;
            tx_data_q   <= data_v[win_idx];
            last_q      <= req_last[win_idx];
            tx_wr_q     <= 1'b1;
            req_ready_q <= win_oh;
            state_q     <= ISSUE;
          end else begin
            grant_q <= '0;
          end
        end
        ISSUE:     state_q <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy) state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q) begin
              rr_ptr_q <= owner_q;
              grant_q  <= '0;
              state_q  <= ARB;
            end else begin
              hold_cnt_q <= '0;
              state_q    <= HOLD;
            end
          end
        end
        HOLD: begin
          // Only the locked owner is looked at here; everyone else waits for ARB.
          if (req_valid[owner_q]) begin
            tx_data_q   <= data_v[owner_q];
            last_q      <= req_last[owner_q];
            tx_wr_q     <= 1'b1;
            req_ready_q <= own_oh;
            state_q     <= ISSUE;
          end else if (hold_cnt_q == HOLD_END) begin
            rr_ptr_q <= owner_q;
            grant_q  <= '0;
            state_q  <= ARB;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;

endmodule
